// File: rtl/speed_sel_ctrl.sv
// Two-key debounced speed select for the LED shift demo: steps a 3-bit mux select up/down.
// Define SEL_WRAP_EN to wrap the select at 0/7 instead of saturating.
module speed_sel_ctrl #(
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned CNT_W      = 20,
  parameter logic [2:0]  S_RESET    = 3'd0
) (
  input  logic       Clk,
  input  logic       RST_N,
  input  logic       KEY_UP,
  input  logic       KEY_DN,
  output logic [2:0] S,
  output logic       SEL_CHG
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEB_CYCLES - 1);

  // Bit 0 is the up key, bit 1 the down key.
  logic [1:0]            key_raw;
  logic [1:0]            sync1_q, sync2_q;
  logic [1:0]            deb_q, deb_d;
  logic [1:0]            press_q, press_d;
  logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            s_q, s_d;
  logic                  chg_q, chg_d;

  assign key_raw = {KEY_DN, KEY_UP};

  always_comb begin
    deb_d   = deb_q;
    press_d = 2'b00;
    cnt_d   = '0;
    for (int k = 0; k < 2; k++) begin
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == CntMax) begin
          deb_d[k]   = sync2_q[k];
          press_d[k] = ~sync2_q[k];  // only the 1->0 flip is a press
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_d   = s_q;
    chg_d = 1'b0;
    case (press_q)
      2'b01: begin
`ifdef SEL_WRAP_EN
        s_d   = s_q + 3'd1;
        chg_d = 1'b1;
`else
        if (s_q != 3'd7) begin
          s_d   = s_q + 3'd1;
          chg_d = 1'b1;
        end
`endif
      end
      2'b10: begin
`ifdef SEL_WRAP_EN
        s_d   = s_q - 3'd1;
        chg_d = 1'b1;
`else
        if (s_q != 3'd0) begin
          s_d   = s_q - 3'd1;
          chg_d = 1'b1;
        end
`endif
      end
      default: ;  // none, or both keys in the same cycle cancel
    endcase
  end

  always_ff @(posedge Clk or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      deb_q   <= 2'b11;
      cnt_q   <= '0;
      press_q <= 2'b00;
      s_q     <= S_RESET;
      chg_q   <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      s_q     <= s_d;
      chg_q   <= chg_d;
    end
  end

  assign S       = s_q;
  assign SEL_CHG = chg_q;

endmodule

// File: tb/tb_speed_sel_ctrl.sv
// Directed bench for speed_sel_ctrl with DEB_CYCLES=4; inputs change and outputs are read
// on the falling edge.
module tb_speed_sel_ctrl;

  logic       Clk = 1'b0;
  logic       RST_N;
  logic       KEY_UP;
  logic       KEY_DN;
  logic [2:0] S;
  logic       SEL_CHG;

  int n_checks = 0;
  int n_pass   = 0;

  speed_sel_ctrl #(
    .DEB_CYCLES(4),
    .CNT_W     (4),
    .S_RESET   (3'd0)
  ) u_dut (
    .Clk    (Clk),
    .RST_N  (RST_N),
    .KEY_UP (KEY_UP),
    .KEY_DN (KEY_DN),
    .S      (S),
    .SEL_CHG(SEL_CHG)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       up_n;
    logic       dn_n;
    logic [2:0] s;
    logic       chg;
  } vec_t;

`ifdef SEL_WRAP_EN
  localparam int SatUpS   = 3;
  localparam int SatUpChg = 5;
  localparam int SatDnS   = 3;
  localparam int SatDnChg = 8;
`else
  localparam int SatUpS   = 7;
  localparam int SatUpChg = 1;
  localparam int SatDnS   = 0;
  localparam int SatDnChg = 7;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Apply raw key levels before one rising edge, return at the next falling edge.
  task automatic cyc(input logic up_n, input logic dn_n);
    KEY_UP = up_n;
    KEY_DN = dn_n;
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // One full press/release; counts SEL_CHG pulses seen.
  task automatic press(input bit up, input bit dn, output int pulses);
    pulses = 0;
    repeat (8) begin
      cyc(!up, !dn);
      if (SEL_CHG) pulses++;
    end
    repeat (8) begin
      cyc(1'b1, 1'b1);
      if (SEL_CHG) pulses++;
    end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    cyc(1'b1, 1'b1);
    RST_N = 1'b1;
  endtask

  vec_t tv[18];
  logic bp[22];
  int   p, tot;

  initial begin
    for (int i = 0; i < 18; i++) begin
      tv[i].up_n = (i < 10) ? 1'b0 : 1'b1;
      tv[i].dn_n = 1'b1;
      tv[i].s    = (i >= 6) ? 3'd1 : 3'd0;
      tv[i].chg  = (i == 6);
    end
    for (int i = 0; i < 22; i++) bp[i] = (i == 3 || i == 7) ? 1'b1 : 1'b0;

    // Reset
    RST_N  = 1'b0;
    KEY_UP = 1'b1;
    KEY_DN = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    chk("reset_s", int'(S), 0);
    chk("reset_chg", int'(SEL_CHG), 0);
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b1);
      chk($sformatf("idle_s[%0d]", i), int'(S), 0);
      chk($sformatf("idle_chg[%0d]", i), int'(SEL_CHG), 0);
    end

    // Clean press, table-driven; index = edge number after first low sample
    for (int i = 0; i < 18; i++) begin
      cyc(tv[i].up_n, tv[i].dn_n);
      chk($sformatf("clean_s[%0d]", i), int'(S), int'(tv[i].s));
      chk($sformatf("clean_chg[%0d]", i), int'(SEL_CHG), int'(tv[i].chg));
    end

    // Bounce: final steady low starts at edge 8, step expected at edge 14
    for (int e = 0; e < 22; e++) begin
      cyc(bp[e], 1'b1);
      chk($sformatf("bounce_s[%0d]", e), int'(S), (e >= 14) ? 2 : 1);
      chk($sformatf("bounce_chg[%0d]", e), int'(SEL_CHG), (e == 14) ? 1 : 0);
    end
    repeat (8) cyc(1'b1, 1'b1);

    // Saturation / wrap
    repeat (4) press(1'b1, 1'b0, p);
    chk("to_six", int'(S), 6);
    tot = 0;
    repeat (5) begin
      press(1'b1, 1'b0, p);
      tot += p;
    end
    chk("sat_up_s", int'(S), SatUpS);
    chk("sat_up_chg", tot, SatUpChg);
    tot = 0;
    repeat (8) begin
      press(1'b0, 1'b1, p);
      tot += p;
    end
    chk("sat_dn_s", int'(S), SatDnS);
    chk("sat_dn_chg", tot, SatDnChg);

    // Simultaneous press from S=3
    do_reset();
    chk("rst2_s", int'(S), 0);
    repeat (3) press(1'b1, 1'b0, p);
    chk("to_three", int'(S), 3);
    for (int e = 0; e < 12; e++) begin
      cyc(1'b0, 1'b0);
      chk($sformatf("both_s[%0d]", e), int'(S), 3);
      chk($sformatf("both_chg[%0d]", e), int'(SEL_CHG), 0);
    end
    repeat (8) cyc(1'b1, 1'b1);
    chk("both_after_s", int'(S), 3);

    // Reset mid-count from S=5 with KEY_DN held
    repeat (2) press(1'b1, 1'b0, p);
    chk("to_five", int'(S), 5);
    repeat (3) cyc(1'b1, 1'b0);
    chk("midcnt_pre_s", int'(S), 5);
    RST_N = 1'b0;
    #1;
    chk("midcnt_rst_s", int'(S), 0);
    chk("midcnt_rst_chg", int'(SEL_CHG), 0);
    cyc(1'b1, 1'b0);
    RST_N = 1'b1;
    for (int e = 0; e < 12; e++) begin
      cyc(1'b1, 1'b0);
`ifdef SEL_WRAP_EN
      chk($sformatf("post_rst_s[%0d]", e), int'(S), (e >= 6) ? 7 : 0);
      chk($sformatf("post_rst_chg[%0d]", e), int'(SEL_CHG), (e == 6) ? 1 : 0);
`else
      chk($sformatf("post_rst_s[%0d]", e), int'(S), 0);
      chk($sformatf("post_rst_chg[%0d]", e), int'(SEL_CHG), 0);
`endif
    end
    repeat (8) cyc(1'b1, 1'b1);

    // A fresh up press after the held-down sequence must still step once
    press(1'b1, 1'b0, p);
    chk("final_up_chg", p, 1);
`ifdef SEL_WRAP_EN
    chk("final_up_s", int'(S), 0);
`else
    chk("final_up_s", int'(S), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
